// File: rtl/qsys_sysid_pkg.sv
// Shared definitions for the QSys system-ID checker.
//   sysid_chk_state_t : checker FSM state encoding
//   SYSID_ADDR_*      : word addresses inside the sysid slave
//   SYSID_DEFAULT_*   : default expected ID / build timestamp
package qsys_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1413589754;

endpackage

// File: rtl/qsys_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID at word 0, timestamp at
// word 1) and compares both words against expected values.
//   clock, reset_n            : clock, async active-low reset
//   start                     : one-cycle run request (ignored while busy)
//   avm_address/read/
//   avm_waitrequest/readdata  : Avalon-MM read master port
//   busy, done, pass          : run status; done is a one-cycle pulse
//   id_mismatch, ts_mismatch,
//   timeout                   : error flags of the last run
//   id_value, ts_value        : words captured in the last run
module qsys_sysid_checker
  import qsys_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW > 8) ? CW_RAW : 8;
  // The timeout fires on the stalled cycle that would bring the count to
  // TIMEOUT_CYCLES, so read stays high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  sysid_chk_state_t state_q, state_d;
  logic          rd_q, rd_d;
  logic          addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          idm_q, idm_d;
  logic          tsm_q, tsm_d;
  logic          to_q, to_d;
  logic [31:0]   idv_q, idv_d;
  logic [31:0]   tsv_q, tsv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  logic stall_expired;
  assign stall_expired = (TIMEOUT_CYCLES != 0) && avm_waitrequest &&
                         (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    idm_d   = idm_q;
    tsm_d   = tsm_q;
    to_d    = to_q;
    idv_d   = idv_q;
    tsv_d   = tsv_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (start || pend_q) begin
          pend_d  = 1'b0;
          pass_d  = 1'b0;
          idm_d   = 1'b0;
          tsm_d   = 1'b0;
          to_d    = 1'b0;
          idv_d   = '0;
          tsv_d   = '0;
          cnt_d   = '0;
          rd_d    = 1'b1;
          addr_d  = SYSID_ADDR_ID;
          busy_d  = 1'b1;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          idv_d   = avm_readdata;
          idm_d   = (avm_readdata != EXPECTED_ID);
          cnt_d   = '0;
          addr_d  = SYSID_ADDR_TS;
          state_d = RD_TS;
        end else if (stall_expired) begin
          to_d    = 1'b1;
          rd_d    = 1'b0;
          addr_d  = SYSID_ADDR_ID;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          tsv_d   = avm_readdata;
          tsm_d   = (avm_readdata != EXPECTED_TIMESTAMP);
          rd_d    = 1'b0;
          addr_d  = SYSID_ADDR_ID;
          done_d  = 1'b1;
          // pass is resolved on DONE entry so it is valid alongside done
          pass_d  = !(idm_q || (avm_readdata != EXPECTED_TIMESTAMP) || to_q);
          state_d = DONE;
        end else if (stall_expired) begin
          to_d    = 1'b1;
          rd_d    = 1'b0;
          addr_d  = SYSID_ADDR_ID;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      idm_q   <= 1'b0;
      tsm_q   <= 1'b0;
      to_q    <= 1'b0;
      idv_q   <= '0;
      tsv_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      idm_q   <= idm_d;
      tsm_q   <= tsm_d;
      to_q    <= to_d;
      idv_q   <= idv_d;
      tsv_q   <= tsv_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = idm_q;
  assign ts_mismatch = tsm_q;
  assign timeout     = to_q;
  assign id_value    = idv_q;
  assign ts_value    = tsv_q;

endmodule

// File: tb/tb_qsys_sysid_checker.sv
module tb_qsys_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1413589754;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  qsys_sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(TS_OK),
    .TIMEOUT_CYCLES    (4),
    .AUTO_START        (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_mismatch    (id_mismatch),
    .ts_mismatch    (ts_mismatch),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  always #5 clock = ~clock;

  // Slave model: returns the configured words and stalls each read for
  // stall_cfg cycles, or forever when perm_stall is set.
  logic [31:0] slv_id, slv_ts;
  int          stall_cfg;
  logic        perm_stall;
  int          stall_cnt;

  assign avm_readdata    = avm_address ? slv_ts : slv_id;
  assign avm_waitrequest = perm_stall || (avm_read && (stall_cnt < stall_cfg));

  always @(posedge clock) begin
    if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
    else                               stall_cnt <= stall_cnt + 1;
  end

  // Bus monitor: monotonic counters, sampled away from the active edge.
  int   mon_reads, mon_addr1, mon_dones, mon_viol;
  logic prev_read, prev_addr, prev_wait;
  initial begin
    mon_reads = 0; mon_addr1 = 0; mon_dones = 0; mon_viol = 0;
    prev_read = 1'b0; prev_addr = 1'b0; prev_wait = 1'b0;
  end
  always @(negedge clock) begin
    if (reset_n) begin
      if (avm_read) mon_reads = mon_reads + 1;
      if (avm_read && avm_address) mon_addr1 = mon_addr1 + 1;
      if (done) mon_dones = mon_dones + 1;
      if (!avm_read && avm_address) mon_viol = mon_viol + 1;
      if (prev_read && prev_wait && !timeout &&
          (!avm_read || avm_address != prev_addr)) mon_viol = mon_viol + 1;
    end
    prev_read = avm_read;
    prev_addr = avm_address;
    prev_wait = avm_waitrequest;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Observations from the first two cycles of a run.
  logic r1, a1, b1, r2, a2;

  // Pulse start (sampled at edge N) and return the cycle offset of done.
  task automatic do_run(output int lat);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1) begin r1 = avm_read; a1 = avm_address; b1 = busy; end
      if (k == 2) begin r2 = avm_read; a2 = avm_address; end
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic wait_done(output int ok);
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (done) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    logic        exp_pass;
    logic        exp_idm;
    logic        exp_tsm;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, ok, r0, a0, d0, v0;

    vecs[0] = '{32'd0,        TS_OK,        1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'd1,        TS_OK,        1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'd0,        TS_OK + 1,    1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1'b1};
    vecs[4] = '{32'd0,        TS_OK,        1'b1, 1'b0, 1'b0};

    reset_n = 1'b0; start = 1'b0;
    slv_id = 32'd0; slv_ts = TS_OK; stall_cfg = 0; perm_stall = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", {31'd0, avm_address}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);
    check("rst_idv", id_value, 32'd0);
    check("rst_tsv", ts_value, 32'd0);

    // Auto-start after reset release
    reset_n = 1'b1;
    wait_done(ok);
    check("auto_done", ok, 1);
    check("auto_pass", {31'd0, pass}, 32'd1);
    repeat (3) @(negedge clock);

    // Table-driven zero-wait runs
    foreach (vecs[i]) begin
      slv_id = vecs[i].id_w;
      slv_ts = vecs[i].ts_w;
      do_run(lat);
      check($sformatf("v%0d_lat", i), lat, 3);
      check($sformatf("v%0d_c1", i), {29'd0, r1, a1, b1}, 32'b101);
      check($sformatf("v%0d_c2", i), {30'd0, r2, a2}, 32'b11);
      check($sformatf("v%0d_busy3", i), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      check($sformatf("v%0d_flags", i), {29'd0, id_mismatch, ts_mismatch, timeout},
            {29'd0, vecs[i].exp_idm, vecs[i].exp_tsm, 1'b0});
      check($sformatf("v%0d_idv", i), id_value, vecs[i].id_w);
      check($sformatf("v%0d_tsv", i), ts_value, vecs[i].ts_w);
      @(negedge clock);
      check($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
      check($sformatf("v%0d_hold", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
    end

    // Three stall cycles on each read
    slv_id = 32'd0; slv_ts = TS_OK; stall_cfg = 3;
    v0 = mon_viol; r0 = mon_reads;
    do_run(lat);
    check("stall_lat", lat, 9);
    check("stall_pass", {31'd0, pass}, 32'd1);
    check("stall_reads", mon_reads - r0, 8);
    check("stall_stable", mon_viol - v0, 0);
    stall_cfg = 0;
    repeat (2) @(negedge clock);

    // start during RD_TS and at the DONE cycle must not launch another run
    d0 = mon_dones; r0 = mon_reads;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock); start = 1'b1;            // cycle N+2, RD_TS
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("ign_done_cycle", {31'd0, done}, 32'd1);
    start = 1'b1;                              // sampled at DONE->IDLE edge
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(negedge clock);
    check("ign_dones", mon_dones - d0, 1);
    check("ign_reads", mon_reads - r0, 2);
    check("ign_busy", {31'd0, busy}, 32'd0);

    // Permanent stall, timeout after 4 cycles
    perm_stall = 1'b1;
    r0 = mon_reads; a0 = mon_addr1; v0 = mon_viol;
    do_run(lat);
    check("to_lat", lat, 5);
    check("to_reads", mon_reads - r0, 4);
    check("to_addr1", mon_addr1 - a0, 0);
    check("to_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'b001);
    check("to_pass", {31'd0, pass}, 32'd0);
    check("to_idv", id_value, 32'd0);
    check("to_tsv", ts_value, 32'd0);
    check("to_stable", mon_viol - v0, 0);
    repeat (2) @(negedge clock);

    // Reset during RD_ID, then auto-start run
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("mid_inread", {30'd0, avm_read, busy}, 32'b11);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", {27'd0, avm_read, avm_address, busy, done, pass}, 32'd0);
    check("mid_rst_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);
    perm_stall = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(ok);
    check("mid_auto_done", ok, 1);
    check("mid_auto_pass", {31'd0, pass}, 32'd1);
    check("mid_auto_tsv", ts_value, TS_OK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qsys_sysid_checker.md
# qsys_sysid_checker

Avalon-MM master that reads the QSys system-ID slave (ID word at address 0, build timestamp at address 1) and compares both words against expected values. It sits beside the sysid slave on the same control interconnect. It gives board bring-up logic a hardware pass/fail flag without needing a soft CPU. A checker run fires once after reset (optional) and again on every `start` pulse.

## Interface
- `EXPECTED_ID`, 32'd0, expected word at address 0
- `EXPECTED_TIMESTAMP`, 32'd1413589754, expected word at address 1
- `TIMEOUT_CYCLES`, 255, maximum stalled cycles per read; 0 disables the timeout
- `AUTO_START`, 1, when 1 a run starts automatically after reset release
- `clock` input 1: single clock; all logic is on its rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `start` input 1: one-cycle request to begin a run; ignored while `busy`
- `avm_address` output 1: word address (0 = ID, 1 = timestamp)
- `avm_read` output 1: read strobe
- `avm_waitrequest` input 1: slave stall; tie to 0 for zero-wait slaves
- `avm_readdata` input 32: read data, valid in the cycle `avm_read && !avm_waitrequest`
- `busy` output 1: run in progress
- `done` output 1: one-cycle pulse at the end of a run
- `pass` output 1: last run matched both words with no timeout
- `id_mismatch`, `ts_mismatch`, `timeout` output 1 each: sticky error flags for the last run
- `id_value`, `ts_value` output 32 each: words captured in the last run

## Operation
- States: IDLE, RD_ID, RD_TS, DONE.
- IDLE:
  - A `start` pulse, or the first cycle after reset when `AUTO_START` = 1, clears all result flags and both value registers, then moves to RD_ID.
- RD_ID:
  - Drives `avm_read` = 1 and `avm_address` = 0.
  - On `!avm_waitrequest`, captures `avm_readdata` into `id_value` and sets `id_mismatch` = (data != EXPECTED_ID).
  - Then moves to RD_TS.
- RD_TS:
  - Same as RD_ID, but with address 1, `ts_value`, `ts_mismatch` and EXPECTED_TIMESTAMP.
  - Then moves to DONE.
- DONE:
  - Pulses `done` for one cycle.
  - Sets `pass` = !(id_mismatch | ts_mismatch | timeout).
  - Returns to IDLE.
- Avalon rules:
  - `avm_read` and `avm_address` stay stable while `avm_waitrequest` = 1.
  - `avm_read` is 0 in IDLE and DONE.
  - `avm_address` is 0 whenever `avm_read` = 0.
  - A read is never abandoned except on timeout.
- Timeout:
  - A stall counter (8 bits minimum, sized by $clog2(TIMEOUT_CYCLES+1)) clears on entry to each read state.
  - It increments on every cycle in which `avm_read && avm_waitrequest`.
  - When the count reaches TIMEOUT_CYCLES, the block drops `avm_read`, sets `timeout` and goes to DONE.
  - In that case the unread value register stays 0 and its mismatch flag stays 0.
- `start` is ignored outside IDLE; there is no queueing.
- A `start` in the same cycle as the DONE→IDLE transition is also ignored.
- Reset mid-run: everything returns to its reset values immediately. There is no bus completion. With `AUTO_START` = 1, a new run begins after release.

## Timing
- Reset values:
  - State IDLE.
  - `avm_read`, `avm_address`, `busy`, `done`, `pass`, all error flags: 0.
  - `id_value`, `ts_value`: 0.
  - Auto-start pending = `AUTO_START`.
- All outputs are registered.
- Zero-wait-state run, with `start` sampled high at edge N:
  - `avm_read` = 1 with address 0 in cycle N+1.
  - Address 1 in cycle N+2.
  - `done` = 1 and `pass` valid in cycle N+3.
  - `busy` = 1 in cycles N+1 to N+3.
- Each stall cycle adds one cycle of latency.
- Timeout run:
  - `avm_read` is high for exactly TIMEOUT_CYCLES cycles in the stalled state.
  - `done` follows in the next cycle.
- `pass`, error flags and value registers hold until the next run starts (the clear happens at the IDLE→RD_ID edge).

## Structure
- Package `qsys_sysid_pkg`:
  - State enum `sysid_chk_state_t`.
  - Address constants `SYSID_ADDR_ID` = 1'b0 and `SYSID_ADDR_TS` = 1'b1.
  - Default expected-value constants.
- Single module, no sub-modules. The stall counter is inline.

## Test plan
- Zero-wait slave returning 0 / 1413589754: `done` pulses at N+3, `pass` = 1, no error flags set.
- Slave returns ID 32'h1 at address 0: `id_mismatch` = 1, `pass` = 0, `id_value` = 1; `ts_mismatch` = 0.
- `avm_waitrequest` held for 3 cycles on each read: `avm_read` and `avm_address` stay stable throughout, `done` arrives at N+9, `pass` = 1.
- Permanent waitrequest with TIMEOUT_CYCLES = 4:
  - `avm_read` is high for 4 cycles.
  - `timeout` = 1 and `pass` = 0.
  - `ts_value` = 0.
  - No address-1 read is issued.
- `start` pulsed during RD_TS, and again at the DONE cycle: neither causes a second run.
- `reset_n` asserted during RD_ID, then released with AUTO_START = 1:
  - All outputs are 0 during reset.
  - A fresh run completes with `pass` = 1.
